// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared types and helpers for the two-wide instruction queue
//
// Purpose: fetch-packet and queue-entry typedefs plus the default queue depth.
// Contents:
//   IQ_DEPTH_DEFAULT  default number of single-instruction entries
//   iq_entry_t        one stored instruction {pc, inst}
//   f_d_pkg_t         two-slot fetch packet {mask, pc[2], inst[2]}
//   popcount2         number of set bits in a 2-bit slot mask
package inst_queue_pkg;

    localparam int IQ_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    typedef struct packed {
        logic [1:0]       mask;
        logic [1:0][31:0] pc;
        logic [1:0][31:0] inst;
    } f_d_pkg_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/inst_queue_compact.sv
// rtl/inst_queue_compact.sv - maps a sparse 2-slot fetch packet onto dense write slots
//
// Purpose: decides how many entries a fetch packet writes and which instruction
//          lands at tail and at tail+1, so the oldest valid slot is always first.
// Ports:
//   pkt        in   fetch packet (mask, per-slot pc/inst)
//   n_in       out  number of valid instructions (0..2)
//   wr0_valid  out  an entry is written at tail
//   wr1_valid  out  an entry is written at tail+1
//   wr0, wr1   out  entries to write at tail / tail+1
import inst_queue_pkg::*;

module iq_compact (
    input  f_d_pkg_t   pkt,
    output logic [1:0] n_in,
    output logic       wr0_valid,
    output logic       wr1_valid,
    output iq_entry_t  wr0,
    output iq_entry_t  wr1
);

    always_comb begin
        n_in      = popcount2(pkt.mask);
        wr0_valid = |pkt.mask;
        wr1_valid = &pkt.mask;
        // A lone slot-1 instruction (mask 10) is compacted down to tail.
        if (pkt.mask[0]) begin
            wr0.pc   = pkt.pc[0];
            wr0.inst = pkt.inst[0];
        end else begin
            wr0.pc   = pkt.pc[1];
            wr0.inst = pkt.inst[1];
        end
        wr1.pc   = pkt.pc[1];
        wr1.inst = pkt.inst[1];
    end

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - two-wide compacting instruction buffer between fetch and decode
//
// Purpose: circular buffer of DEPTH single-instruction entries. Accepts 2-slot
//          fetch packets (compacting sparse masks), presents up to two oldest
//          instructions to the decoder, supports a synchronous flush.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush_i                 drop all entries; blocks enqueue/dequeue this cycle
//   in_valid_i/in_ready_o   fetch packet handshake (ready = room for 2)
//   in_mask_i, in_pc_i, in_inst_i   fetch packet contents
//   out_valid_o/out_ready_i decoder handshake
//   out_mask_o              00, 01 or 11; slot 0 is always the oldest
//   out_pc_o, out_inst_o    presented instructions (invalid slots drive 0)
//   count_o                 current occupancy
import inst_queue_pkg::*;

module inst_queue #(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [1:0]               in_mask_i,
    input  logic [1:0][31:0]         in_pc_i,
    input  logic [1:0][31:0]         in_inst_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [1:0]               out_mask_o,
    output logic [1:0][31:0]         out_pc_o,
    output logic [1:0][31:0]         out_inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_HI  = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    f_d_pkg_t   pkt;
    logic [1:0] n_in;
    logic [1:0] n_out;
    logic       wr0_valid;
    logic       wr1_valid;
    iq_entry_t  wr0;
    iq_entry_t  wr1;
    logic       enq;
    logic       deq;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;

    assign pkt.mask = in_mask_i;
    assign pkt.pc   = in_pc_i;
    assign pkt.inst = in_inst_i;

    iq_compact u_compact (
        .pkt       (pkt),
        .n_in      (n_in),
        .wr0_valid (wr0_valid),
        .wr1_valid (wr1_valid),
        .wr0       (wr0),
        .wr1       (wr1)
    );

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Ready only looks at registered occupancy: two free entries guarantee a
    // full packet fits and that writes never collide with the entries read.
    assign in_ready_o = (count <= CNT_HI);

    assign out_valid_o = (count != '0);
    assign out_mask_o  = (count >= (PTR_W+1)'(2)) ? 2'b11 :
                         (count == (PTR_W+1)'(1)) ? 2'b01 : 2'b00;
    assign n_out       = popcount2(out_mask_o);

    always_comb begin
        out_pc_o   = '0;
        out_inst_o = '0;
        if (out_mask_o[0]) begin
            out_pc_o[0]   = mem[head].pc;
            out_inst_o[0] = mem[head].inst;
        end
        if (out_mask_o[1]) begin
            out_pc_o[1]   = mem[head_p1].pc;
            out_inst_o[1] = mem[head_p1].inst;
        end
    end

    assign enq = in_valid_i && in_ready_o && !flush_i;
    assign deq = out_valid_o && out_ready_i && !flush_i;

    assign count_o = count;

    // Storage carries no reset; validity is tracked solely by head/count.
    always_ff @(posedge clk) begin
        if (enq && wr0_valid) begin
            mem[tail] <= wr0;
        end
        if (enq && wr1_valid) begin
            mem[tail_p1] <= wr1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(n_in);
            end
            if (deq) begin
                head <= head + PTR_W'(n_out);
            end
            count <= count
                   + (enq ? (PTR_W+1)'(n_in)  : '0)
                   - (deq ? (PTR_W+1)'(n_out) : '0);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_MAX);
    a_mask_legal: assert property (@(posedge clk) disable iff (!rst_n)
        out_mask_o != 2'b10);
    a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && (count > CNT_HI)));

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue
module tb_inst_queue;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0]       in_mask_i;
    logic [1:0][31:0] in_pc_i;
    logic [1:0][31:0] in_inst_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [1:0]       out_mask_o;
    logic [1:0][31:0] out_pc_o;
    logic [1:0][31:0] out_inst_o;
    logic [3:0]       count_o;

    int n_checks;
    int n_fail;

    inst_queue #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_mask_i   (in_mask_i),
        .in_pc_i     (in_pc_i),
        .in_inst_i   (in_inst_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_mask_o  (out_mask_o),
        .out_pc_o    (out_pc_o),
        .out_inst_o  (out_inst_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [1:0] m, input logic [31:0] pc0, input logic [31:0] pc1);
        in_valid_i = 1'b1;
        in_mask_i  = m;
        in_pc_i[0] = pc0;
        in_pc_i[1] = pc1;
        in_inst_i[0] = pc0 ^ 32'h0000_0013;
        in_inst_i[1] = pc1 ^ 32'h0000_0013;
    endtask

    task automatic idle_in();
        in_valid_i = 1'b0;
        in_mask_i  = 2'b00;
        in_pc_i    = '0;
        in_inst_i  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        idle_in();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
        n_checks++; if (out_mask_o !== 2'b00) begin n_fail++; $display("FAIL reset_mask got %b want 00", out_mask_o); end
    endtask

    task automatic test_enqueue_pair();
        out_ready_i = 1'b0;
        set_pkt(2'b11, 32'h1c00_0000, 32'h1c00_0004);
        step();
        idle_in();
        n_checks++; if (out_mask_o !== 2'b11) begin n_fail++; $display("FAIL pair_mask got %b want 11", out_mask_o); end
        n_checks++; if (out_pc_o[0] !== 32'h1c00_0000) begin n_fail++; $display("FAIL pair_pc0 got %h want 1c000000", out_pc_o[0]); end
        n_checks++; if (out_pc_o[1] !== 32'h1c00_0004) begin n_fail++; $display("FAIL pair_pc1 got %h want 1c000004", out_pc_o[1]); end
        n_checks++; if (out_inst_o[1] !== 32'h1c00_0017) begin n_fail++; $display("FAIL pair_inst1 got %h want 1c000017", out_inst_o[1]); end
        n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL pair_count got %0d want 2", count_o); end
        // Held with out_ready low: outputs must not move.
        step();
        n_checks++; if (out_pc_o[0] !== 32'h1c00_0000) begin n_fail++; $display("FAIL pair_hold_pc0 got %h want 1c000000", out_pc_o[0]); end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL pair_drain_count got %0d want 0", count_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL pair_drain_valid got %b want 0", out_valid_o); end
    endtask

    task automatic test_sparse();
        out_ready_i = 1'b0;
        set_pkt(2'b10, 32'hdead_beef, 32'h1c00_0014);
        step();
        idle_in();
        n_checks++; if (out_mask_o !== 2'b01) begin n_fail++; $display("FAIL sparse_mask got %b want 01", out_mask_o); end
        n_checks++; if (out_pc_o[0] !== 32'h1c00_0014) begin n_fail++; $display("FAIL sparse_pc0 got %h want 1c000014", out_pc_o[0]); end
        n_checks++; if (out_pc_o[1] !== 32'h0) begin n_fail++; $display("FAIL sparse_pc1_zero got %h want 0", out_pc_o[1]); end
        n_checks++; if (out_inst_o[1] !== 32'h0) begin n_fail++; $display("FAIL sparse_inst1_zero got %h want 0", out_inst_o[1]); end
        n_checks++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL sparse_count got %0d want 1", count_o); end
        set_pkt(2'b11, 32'h1c00_0018, 32'h1c00_001c);
        step();
        idle_in();
        n_checks++; if (out_mask_o !== 2'b11) begin n_fail++; $display("FAIL widen_mask got %b want 11", out_mask_o); end
        n_checks++; if (out_pc_o[0] !== 32'h1c00_0014) begin n_fail++; $display("FAIL widen_pc0 got %h want 1c000014", out_pc_o[0]); end
        n_checks++; if (out_pc_o[1] !== 32'h1c00_0018) begin n_fail++; $display("FAIL widen_pc1 got %h want 1c000018", out_pc_o[1]); end
        n_checks++; if (count_o !== 4'd3) begin n_fail++; $display("FAIL widen_count got %0d want 3", count_o); end
        out_ready_i = 1'b1;
        step();
        n_checks++; if (out_pc_o[0] !== 32'h1c00_001c) begin n_fail++; $display("FAIL sparse_tail_pc0 got %h want 1c00001c", out_pc_o[0]); end
        n_checks++; if (out_mask_o !== 2'b01) begin n_fail++; $display("FAIL sparse_tail_mask got %b want 01", out_mask_o); end
        step();
        out_ready_i = 1'b0;
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL sparse_empty got %0d want 0", count_o); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_pkt(2'b11, 32'h1c00_0100 + 32'(16*k), 32'h1c00_0104 + 32'(16*k));
            step();
            n_checks++; if (count_o !== 4'(2*(k+1))) begin n_fail++; $display("FAIL bp_count_%0d got %0d want %0d", k, count_o, 2*(k+1)); end
            n_checks++; if (in_ready_o !== (k < 3)) begin n_fail++; $display("FAIL bp_ready_%0d got %b want %b", k, in_ready_o, (k < 3)); end
        end
        // Fifth packet offered while full: must be ignored.
        set_pkt(2'b11, 32'h1c00_0200, 32'h1c00_0204);
        step();
        step();
        n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL bp_hold_count got %0d want 8", count_o); end
        n_checks++; if (out_pc_o[0] !== 32'h1c00_0100) begin n_fail++; $display("FAIL bp_hold_pc0 got %h want 1c000100", out_pc_o[0]); end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        n_checks++; if (count_o !== 4'd6) begin n_fail++; $display("FAIL bp_deq_count got %0d want 6", count_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_reready got %b want 1", in_ready_o); end
        step();
        idle_in();
        n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL bp_accept_count got %0d want 8", count_o); end
        out_ready_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            exp_pc = (k == 4) ? 32'h1c00_0200 : 32'h1c00_0100 + 32'(16*k);
            n_checks++; if (out_pc_o[0] !== exp_pc) begin n_fail++; $display("FAIL bp_order_%0d got %h want %h", k, out_pc_o[0], exp_pc); end
            step();
        end
        out_ready_i = 1'b0;
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL bp_final_count got %0d want 0", count_o); end
    endtask

    task automatic test_wrap();
        logic [31:0] base;
        for (int i = 0; i < 10; i++) begin
            base = 32'h1c00_1000 + 32'(8*i);
            out_ready_i = 1'b0;
            set_pkt(2'b11, base, base + 32'd4);
            step();
            idle_in();
            n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL wrap_count_%0d got %0d want 2", i, count_o); end
            n_checks++; if (out_pc_o[0] !== base || out_pc_o[1] !== base + 32'd4) begin n_fail++; $display("FAIL wrap_pc_%0d got %h/%h want %h/%h", i, out_pc_o[0], out_pc_o[1], base, base + 32'd4); end
            out_ready_i = 1'b1;
            step();
            n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL wrap_drain_%0d got %0d want 0", i, count_o); end
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        set_pkt(2'b11, 32'h1c00_2000, 32'h1c00_2004); step();
        set_pkt(2'b11, 32'h1c00_2008, 32'h1c00_200c); step();
        set_pkt(2'b10, 32'h0, 32'h1c00_2010); step();
        n_checks++; if (count_o !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count got %0d want 5", count_o); end
        set_pkt(2'b11, 32'h1c00_3000, 32'h1c00_3004);
        out_ready_i = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        idle_in();
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", in_ready_o); end
        set_pkt(2'b11, 32'h1c00_3000, 32'h1c00_3004);
        step();
        idle_in();
        n_checks++; if (out_pc_o[0] !== 32'h1c00_3000) begin n_fail++; $display("FAIL reissue_pc0 got %h want 1c003000", out_pc_o[0]); end
        n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL reissue_count got %0d want 2", count_o); end
    endtask

    task automatic test_back_to_back();
        // Queue holds 2 (from the reissue); dequeue 2 and enqueue 2 together.
        out_ready_i = 1'b1;
        set_pkt(2'b11, 32'h1c00_4000, 32'h1c00_4004);
        step();
        set_pkt(2'b01, 32'h1c00_4008, 32'h0);
        n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", count_o); end
        n_checks++; if (out_pc_o[0] !== 32'h1c00_4000) begin n_fail++; $display("FAIL b2b_pc0 got %h want 1c004000", out_pc_o[0]); end
        step();
        idle_in();
        n_checks++; if (count_o !== 4'd1 || out_pc_o[0] !== 32'h1c00_4008) begin n_fail++; $display("FAIL b2b_single got %0d/%h want 1/1c004008", count_o, out_pc_o[0]); end
        set_pkt(2'b00, 32'h0, 32'h0);
        out_ready_i = 1'b0;
        step();
        idle_in();
        n_checks++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL empty_mask_count got %0d want 1", count_o); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_enqueue_pair();
        test_sparse();
        test_backpressure();
        test_wrap();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Two-wide instruction buffer between the fetch stage (f_d_pkg_t producer) and the combinational decoder.
- Holds the F-to-D pipeline register state for the D stage.
- Compacts sparse fetch packets so decoder slot 0 always carries the oldest instruction.
- Absorbs fetch/rename rate mismatch and supports a pipeline flush.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridable).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- flush_i  input  1  synchronous flush of all entries (branch mispredict / exception)
- in_valid_i  input  1  fetch packet valid
- in_ready_o  input-side output  1  queue can accept a full packet
- in_mask_i  input  2  per-slot valid of fetch packet (preict_info.mask)
- in_pc_i  input  2x32  per-slot PC
- in_inst_i  input  2x32  per-slot instruction word
- out_valid_o  output  1  at least one instruction presented
- out_ready_i  input  1  decoder/rename accepts this cycle
- out_mask_o  output  2  valid slots presented; only 00, 01 or 11
- out_pc_o  output  2x32  PC of oldest (slot 0) and next (slot 1)
- out_inst_o  output  2x32  instruction words, same ordering
- count_o  output  PTR_W+1  current occupancy (debug/perf)

Behaviour:
- Storage: circular array of DEPTH entries {pc, inst}; head ptr, tail ptr (PTR_W bits, natural wrap), count (PTR_W+1 bits).
- Reset (rst_n low, async): head=0, tail=0, count=0. Outputs: out_valid_o=0, out_mask_o=00, in_ready_o=1, count_o=0. Array contents are don't-care and need no reset.
- in_ready_o = (count <= DEPTH-2). It depends on registered count only; there is no combinational path from out_ready_i.
- Enqueue fires when in_valid_i && in_ready_o && !flush_i. The number written is n_in = popcount(in_mask_i).
  - Valid slots are written in slot order (slot 0 first) at tail, tail+1.
  - tail advances by n_in.
  - A mask of 10 writes the slot-1 instruction at tail.
  - A mask of 00 is accepted with no state change.
- Output is combinational from array at head/head+1:
  - out_valid_o = (count != 0)
  - out_mask_o = 11 if count >= 2; 01 if count == 1; 00 if empty
  - Slots that are not valid drive 0 on pc/inst.
- Dequeue fires when out_valid_o && out_ready_i && !flush_i. It removes n_out = popcount(out_mask_o); head advances by n_out.
- Simultaneous enqueue and dequeue: count_next = count + n_in - n_out. A write never targets an entry being read in the same cycle, because of the 2-entry headroom.
- Latency: an instruction enqueued in cycle t is visible at the output in cycle t+1 at the earliest. There is no bypass.
- Flush (flush_i=1): next cycle head=tail=0 and count=0. It overrides enqueue and dequeue in the same cycle, so neither fires. out_valid_o may still be high during the flush cycle, but no transfer is counted.
- Full: count in {DEPTH-1, DEPTH} gives in_ready_o=0. The fetch packet must be held stable by the producer (handshake_if rules).
- Stability: while out_valid_o && !out_ready_i, outputs hold their values unless an enqueue changes out_mask_o from 01 to 11. This widening is permitted; the oldest slot never changes.
- Wrap-around: pointer arithmetic is modulo DEPTH. tail+1 and head+1 wrap independently.
- Assertions:
  - count <= DEPTH always.
  - out_mask_o != 10.
  - No enqueue when count > DEPTH-2.

Decomposition:
- Shared package (a_decoder.svh / core package): the f_d_pkg_t fetch packet typedef and an iq_entry_t {pc, inst} typedef. DEPTH's default constant also belongs there.
- A top-level wrapper binds handshake_if.receiver/sender to the plain ports.
- Sub-module: none required. An optional helper, iq_compact, holds the 2-slot mask-to-write-index logic.

Test Plan:
- Reset: hold rst_n=0, release → out_valid_o=0, in_ready_o=1, count_o=0.
- Enqueue mask 11 (pc 0x1c000000/0x1c000004) with out_ready_i=0, then raise out_ready_i → next cycle out_mask_o=11 with those PCs in order; after dequeue count_o=0.
- Enqueue mask 10 (pc1 0x1c000014), then mask 11 (0x1c000018/0x1c00001c) → output slot0=0x1c000014 mask 01, then widens to 11 with slot1=0x1c000018.
- Backpressure: out_ready_i=0, enqueue four 11 packets (DEPTH=8) → in_ready_o drops once count_o=8; a fifth packet is held and not written; one dequeue of 2 reasserts in_ready_o.
- Wrap: 20 alternating cycles of enqueue 11 and dequeue 11 → PCs emerge strictly in order across pointer wrap; count_o stays ≤2.
- Flush with simultaneous enqueue at count_o=5 → next cycle count_o=0, out_valid_o=0; the packet is dropped and must be reissued.
